// File: rtl/dsp_op_handshake_adapter.sv
// Initiator-side wrapper for fixed-latency, non-stallable DSP operators.
// Operands arrive on a valid/ready stream and are passed straight to the DSP.
// A LATENCY-deep valid pipeline tracks operations in flight. Returning results
// land in a FIFO. Credits are counted over in-flight ops plus buffered entries,
// so a stalled consumer can never cause a result to be dropped.
module dsp_op_handshake_adapter #(
    parameter int OPERAND_W  = 32,
    parameter int RESULT_W   = 32,
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [OPERAND_W-1:0]               in_x,
    input  logic [OPERAND_W-1:0]               in_y,
    output logic [OPERAND_W-1:0]               dsp_x_out,
    output logic [OPERAND_W-1:0]               dsp_y_out,
    output logic                               dsp_valid_out,
    input  logic [RESULT_W-1:0]                dsp_result_in,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [RESULT_W-1:0]                out_result,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    occupancy_out
);

    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    generate
        if (LATENCY < 1) begin : g_bad_latency
            $fatal(1, "dsp_op_handshake_adapter: LATENCY must be >= 1");
        end
        if (FIFO_DEPTH < 1) begin : g_bad_depth
            $fatal(1, "dsp_op_handshake_adapter: FIFO_DEPTH must be >= 1");
        end
    endgenerate

    logic [LATENCY-1:0]  r_vld_sr;
    logic [OCC_W-1:0]    r_occ;
    logic [OCC_W-1:0]    r_cnt;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [RESULT_W-1:0] r_mem [FIFO_DEPTH];

    logic w_in_ready;
    logic w_accept;
    logic w_out_valid;
    logic w_pop;
    logic w_wr;

    // in_ready comes only from the registered credit count, never from out_ready.
    assign w_in_ready  = !rst && (r_occ < DEPTH_C);
    assign w_accept    = in_valid && w_in_ready;
    assign w_out_valid = !rst && (r_cnt != '0);
    assign w_pop       = w_out_valid && out_ready;
    assign w_wr        = r_vld_sr[LATENCY-1];

    assign in_ready      = w_in_ready;
    assign dsp_x_out     = in_x;
    assign dsp_y_out     = in_y;
    assign dsp_valid_out = w_accept;
    assign out_valid     = w_out_valid;
    assign out_result    = r_mem[r_rd_ptr];
    assign occupancy_out = rst ? '0 : r_occ;

    // Valid pipeline: bit LATENCY-1 marks the cycle in which dsp_result_in is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_sr <= '0;
        end else begin
            r_vld_sr[0] <= w_accept;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld_sr[i] <= r_vld_sr[i-1];
            end
        end
    end

    // Credit counter over in-flight ops plus buffered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // FIFO pointers and fill count; the pointers wrap at FIFO_DEPTH, so any depth works.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_cnt <= r_cnt + OCC_W'(1);
                2'b01:   r_cnt <= r_cnt - OCC_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // FIFO storage is data only and is left unreset; out_result is meaningless while empty.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= dsp_result_in;
        end
    end

    // Guards: the credit scheme must keep the FIFO from overflowing, and control inputs must be known.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!$isunknown(in_valid));
            assert (!$isunknown(out_ready));
            assert (!(w_wr && (r_cnt == DEPTH_C) && !w_pop));
        end
    end

endmodule

// File: tb/tb_dsp_op_handshake_adapter.sv
// Bench for dsp_op_handshake_adapter. Two instances are used: depth 8 for the
// main scenarios and depth 5 for the non-power-of-two wrap scenario. Each
// instance drives a umul27 mock with latency 4. A queue-based reference model
// predicts handshakes, occupancy and the timing and value of every result.
module tb_dsp_op_handshake_adapter;

    localparam int LAT = 4;

    typedef struct {
        logic [31:0] d;
        int          t;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    // depth-8 instance
    logic        iv8, ir8, dv8, ov8, or8;
    logic [31:0] x8, y8, dx8, dy8, dr8, res8;
    logic [3:0]  occ8;
    // depth-5 instance
    logic        iv5, ir5, dv5, ov5, or5;
    logic [31:0] x5, y5, dx5, dy5, dr5, res5;
    logic [2:0]  occ5;

    logic [31:0] pipe8 [LAT];
    logic [31:0] pipe5 [LAT];

    exp_t q8[$];
    exp_t q5[$];
    int   m_occ8 = 0;
    int   m_occ5 = 0;
    int   pops5  = 0;

    dsp_op_handshake_adapter #(.OPERAND_W(32), .RESULT_W(32), .LATENCY(LAT), .FIFO_DEPTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_x(x8), .in_y(y8),
        .dsp_x_out(dx8), .dsp_y_out(dy8), .dsp_valid_out(dv8), .dsp_result_in(dr8),
        .out_valid(ov8), .out_ready(or8), .out_result(res8), .occupancy_out(occ8)
    );

    dsp_op_handshake_adapter #(.OPERAND_W(32), .RESULT_W(32), .LATENCY(LAT), .FIFO_DEPTH(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(iv5), .in_ready(ir5), .in_x(x5), .in_y(y5),
        .dsp_x_out(dx5), .dsp_y_out(dy5), .dsp_valid_out(dv5), .dsp_result_in(dr5),
        .out_valid(ov5), .out_ready(or5), .out_result(res5), .occupancy_out(occ5)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mul27(input logic [31:0] a, input logic [31:0] b);
        logic [53:0] p;
        p = a[26:0] * b[26:0];
        return p[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fixed-latency DSP mocks; idle cycles return junk so ungated captures show up.
    always @(posedge clk) begin
        pipe8[0] <= dv8 ? mul27(dx8, dy8) : $urandom;
        for (int k = 1; k < LAT; k++) pipe8[k] <= pipe8[k-1];
    end
    always @(posedge clk) begin
        pipe5[0] <= dv5 ? mul27(dx5, dy5) : $urandom;
        for (int k = 1; k < LAT; k++) pipe5[k] <= pipe5[k-1];
    end
    assign dr8 = pipe8[LAT-1];
    assign dr5 = pipe5[LAT-1];

    // Reference model for the depth-8 instance, evaluated mid-cycle.
    always @(negedge clk) begin
        logic eov;
        logic acc;
        exp_t e;
        if (rst) begin
            chk("rst_in_ready", ir8, 0);
            chk("rst_out_valid", ov8, 0);
            chk("rst_occupancy", occ8, 0);
            chk("rst_dsp_valid", dv8, 0);
            q8.delete();
            m_occ8 = 0;
        end else begin
            eov = 1'b0;
            if (q8.size() > 0) eov = (q8[0].t <= cyc);
            acc = iv8 && (m_occ8 < 8);
            chk("in_ready", ir8, m_occ8 < 8);
            chk("dsp_valid", dv8, acc);
            chk("dsp_x", dx8, x8);
            chk("dsp_y", dy8, y8);
            chk("occupancy", occ8, m_occ8);
            chk("out_valid", ov8, eov);
            if (eov) chk("out_result", res8, q8[0].d);
            if (eov && or8) begin
                void'(q8.pop_front());
                m_occ8--;
            end
            if (acc) begin
                e.d = x8 * y8;
                e.t = cyc + LAT + 1;
                q8.push_back(e);
                m_occ8++;
            end
        end
    end

    // Reference model for the depth-5 instance.
    always @(negedge clk) begin
        logic eov;
        logic acc;
        exp_t e;
        if (rst) begin
            chk("w_rst_out_valid", ov5, 0);
            chk("w_rst_occupancy", occ5, 0);
            q5.delete();
            m_occ5 = 0;
        end else begin
            eov = 1'b0;
            if (q5.size() > 0) eov = (q5[0].t <= cyc);
            acc = iv5 && (m_occ5 < 5);
            chk("w_in_ready", ir5, m_occ5 < 5);
            chk("w_occupancy", occ5, m_occ5);
            chk("w_out_valid", ov5, eov);
            if (eov) chk("w_out_result", res5, q5[0].d);
            if (eov && or5) begin
                void'(q5.pop_front());
                m_occ5--;
                pops5++;
            end
            if (acc) begin
                e.d = x5 * y5;
                e.t = cyc + LAT + 1;
                q5.push_back(e);
                m_occ5++;
            end
        end
    end

    initial begin
        int nacc;
        int t0;
        int guard;
        iv8 = 0; x8 = 0; y8 = 0; or8 = 1;
        iv5 = 0; x5 = 0; y5 = 0; or5 = 1;
        rst = 1;
        while (cyc < 3) step();
        rst = 0;
        @(negedge clk);
        chk("post_reset_in_ready", ir8, 1);
        chk("post_reset_occupancy", occ8, 0);

        // Single op: latency and data
        while (cyc < 10) step();
        iv8 = 1; x8 = 3; y8 = 5;
        @(negedge clk);
        chk("lat_dsp_valid", dv8, 1);
        step();
        iv8 = 0;
        while (cyc < 15) step();
        @(negedge clk);
        chk("lat_out_valid_15", ov8, 1);
        chk("lat_out_result_15", res8, 15);
        step();
        @(negedge clk);
        chk("lat_out_valid_16", ov8, 0);

        // Streaming, 20 back-to-back ops
        for (int i = 0; i < 20; i++) begin
            x8 = i; y8 = i + 1; iv8 = 1;
            @(negedge clk);
            chk("stream_in_ready", ir8, 1);
            step();
        end
        iv8 = 0;
        repeat (12) step();

        // Backpressure: 10 offered, 8 taken
        or8 = 0; nacc = 0;
        for (int j = 0; j < 10; j++) begin
            iv8 = 1; x8 = j + 1; y8 = 2;
            @(negedge clk);
            if (iv8 && ir8) nacc++;
            step();
        end
        chk("bp_accepts", nacc, 8);
        // Full with simultaneous pop and offer
        or8 = 1; iv8 = 1; x8 = 100; y8 = 1;
        @(negedge clk);
        chk("full_in_ready", ir8, 0);
        chk("full_occupancy", occ8, 8);
        step();
        @(negedge clk);
        chk("after_pop_occupancy", occ8, 7);
        chk("after_pop_in_ready", ir8, 1);
        step();
        iv8 = 0;
        repeat (20) step();

        // Reset mid-flight
        for (int j = 0; j < 3; j++) begin
            iv8 = 1; x8 = 7 + j; y8 = 3;
            step();
        end
        iv8 = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        chk("midrst_occupancy", occ8, 0);
        chk("midrst_out_valid", ov8, 0);
        step();
        t0 = cyc;
        iv8 = 1; x8 = 2; y8 = 2;
        step();
        iv8 = 0;
        while (cyc < t0 + 5) step();
        @(negedge clk);
        chk("postrst_out_valid", ov8, 1);
        chk("postrst_out_result", res8, 4);
        step();

        // Random traffic on the depth-8 instance
        for (int j = 0; j < 300; j++) begin
            iv8 = ($urandom % 4) != 0;
            x8 = $urandom_range(0, 65535);
            y8 = $urandom_range(0, 65535);
            or8 = ($urandom % 3) != 0;
            step();
        end
        iv8 = 0; or8 = 1;
        repeat (20) step();
        chk("rand_drained", q8.size(), 0);

        // Wrap scenario on the depth-5 instance
        nacc = 0; guard = 0;
        while (nacc < 37 && guard < 2000) begin
            iv5 = 1;
            x5 = $urandom_range(0, 65535);
            y5 = $urandom_range(0, 65535);
            or5 = $urandom % 2;
            @(negedge clk);
            if (iv5 && ir5) nacc++;
            step();
            guard++;
        end
        iv5 = 0; or5 = 1;
        chk("wrap_accepts", nacc, 37);
        repeat (20) step();
        chk("wrap_pops", pops5, 37);
        chk("wrap_drained", q5.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dsp_op_handshake_adapter.md
Name: dsp_op_handshake_adapter

Overview:
- Initiator-side wrapper for the fixed-latency, non-stallable `_hardware_dsp__*` operators (umul27, imul27, fmul32, fadd32, ...).
- Accepts operands on a valid/ready stream and issues them to the DSP with `op_valid`.
- Tracks in-flight operations with a LATENCY-deep valid pipeline.
- Captures returning results in a credit-protected FIFO, so a stalling downstream consumer never loses a result.

Parameters:
- OPERAND_W, 32, width of each of the operands x and y.
- RESULT_W, 32, width of the DSP result.
- LATENCY, 4, cycles from DSP operand sample to valid `dsp_result_in`; must be >= 1 (checked by `$fatal` at elaboration).
- FIFO_DEPTH, 8, result FIFO entries; must be >= 1 (checked by `$fatal`).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream operand valid
- in_ready  out  1  upstream operand ready
- in_x  in  OPERAND_W  operand x
- in_y  in  OPERAND_W  operand y
- dsp_x_out  out  OPERAND_W  to DSP `op_x_in`
- dsp_y_out  out  OPERAND_W  to DSP `op_y_in`
- dsp_valid_out  out  1  to DSP `op_valid_in`
- dsp_result_in  in  RESULT_W  from DSP `op_result_out`
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_result  out  RESULT_W  result data
- occupancy_out  out  $clog2(FIFO_DEPTH+1)  in-flight ops plus FIFO entries (debug)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Accept:
  - accept = in_valid && in_ready.
  - in_ready = !rst && (occupancy < FIFO_DEPTH).
  - in_ready does not depend combinationally on out_ready.
- DSP drive:
  - dsp_x_out = in_x and dsp_y_out = in_y, combinational pass-through.
  - dsp_valid_out = accept.
  - The DSP samples the operands on the same edge that completes the accept.
- In-flight tracking:
  - vld_sr is a LATENCY-bit shift register; vld_sr[0] <= accept.
  - vld_sr[LATENCY-1] high means dsp_result_in is valid in that cycle.
- Capture: when vld_sr[LATENCY-1] is high, dsp_result_in is written to the FIFO at the end of that cycle.
  - Overflow is impossible by credit construction.
  - An assertion fires if a write occurs while the FIFO is full.
- Latency: an operand accepted in cycle T appears on out_valid/out_result in cycle T+LATENCY+1 when the FIFO was empty.
- FIFO behaviour:
  - First-word-fall-through, registered: out_valid = !empty, and out_result = the head entry.
  - pop = out_valid && out_ready.
- Occupancy counter:
  - Increments on accept and decrements on pop.
  - Net zero on a simultaneous accept and pop.
  - Range is 0..FIFO_DEPTH.
- Boundaries:
  - occupancy == FIFO_DEPTH: in_ready=0. A pop in the same cycle does not raise in_ready until the next cycle (registered count).
  - FIFO full with a simultaneous write and pop: both take effect and the count is unchanged.
  - FIFO empty with a simultaneous write and pop: impossible, because out_valid=0 while empty.
  - Pointer wrap-around: pointers wrap modulo FIFO_DEPTH; non-power-of-2 depths are supported.
- Ordering: results leave in strict acceptance order.
- Throughput: 1 op/cycle sustained while out_ready is held high.
- Reset:
  - Clears vld_sr, the FIFO pointers and occupancy.
  - During rst: in_ready=0, dsp_valid_out=0, out_valid=0, occupancy_out=0.
  - Reset mid-operation discards every in-flight and buffered result.
  - The DSP's own accumulator state (fmac32) is reset by the shared rst.
- Data contents of the FIFO are not reset; out_result is don't-care while out_valid=0.
- X handling: an X on in_valid or out_ready is a simulation assertion error.

Test Plan:
- Latency/data: LATENCY=4, FIFO_DEPTH=8, DSP = umul27 mock. Accept x=3, y=5 at cycle 10 → dsp_valid_out=1 at cycle 10; out_valid=1 with out_result=15 at cycle 15; out_valid=0 at cycle 16.
- Streaming: 20 back-to-back ops x=i, y=i+1 (i=0..19) with out_ready=1 → in_ready stays 1 throughout; results 0, 2, 6, ..., 380 emerge in order, one per cycle.
- Backpressure:
  - out_ready=0 while 10 ops are offered → exactly 8 accepted; in_ready=0 from the cycle after the 8th accept; occupancy_out=8.
  - Raise out_ready → the 8 results drain in order, and in_ready returns 1 one cycle after the first pop.
- Simultaneous accept and pop at full: out_ready=1 and in_valid=1 with occupancy at 8 → in_ready stays 0 that cycle; next cycle occupancy=7, in_ready=1; no result lost or duplicated.
- Reset mid-flight: accept 3 ops, assert rst for 1 cycle two cycles later → out_valid never asserts for those ops; occupancy_out=0 after reset; the next op x=2, y=2 yields 4 at T+5.
- Wrap: FIFO_DEPTH=5, 37 ops with random out_ready (50%) → scoreboard shows in-order, no loss, and pointers wrapped at least 7 times.
